// File: rtl/ram16_access_ctrl_pkg.sv
// Shared widths and controller state encoding for the RAM16 access controller.
package ram16_access_ctrl_pkg;

  localparam int unsigned RAM_ADDR_W = 4;
  localparam int unsigned RAM_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_CLEAR  = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/ram16_access_ctrl_clear_seq.sv
// Address sweep counter for the post-reset clear; counts 0..2**ADDR_W-1 once, then holds done.
module ram16_clear_seq #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step,
  output logic [ADDR_W-1:0] count,
  output logic              done
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      done  <= 1'b0;
    end else if (step && !done) begin
      count <= count + 1'b1;
      if (count == '1) done <= 1'b1;
    end
  end

endmodule

// File: rtl/ram16_access_ctrl.sv
// Valid/ready front end serialising single-word accesses onto a RAM16 port.
// Optional post-reset clear sweep enabled by defining CLEAR_ON_RESET_EN.
module ram16_access_ctrl
  import ram16_access_ctrl_pkg::*;
#(
  parameter int unsigned          ADDR_W  = RAM_ADDR_W,
  parameter int unsigned          DATA_W  = RAM_DATA_W,
  parameter logic [DATA_W-1:0]    CLR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);

  ctrl_state_t       state;
  logic [ADDR_W-1:0] sweep_addr;
  logic              sweep_done;

`ifdef CLEAR_ON_RESET_EN
  localparam bit CLR_MODE = 1'b1;
  logic clr_step;

  assign clr_step = (state == ST_CLEAR) && !sweep_done;

  ram16_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (clr_step),
    .count (sweep_addr),
    .done  (sweep_done)
  );
`else
  localparam bit CLR_MODE = 1'b0;

  // Without the sweep the CLEAR state is unreachable; ties make it fall straight to IDLE.
  assign sweep_addr = '0;
  assign sweep_done = 1'b1;
`endif

  // ram_we sits on the async reset, so an in-flight write is dropped the instant rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CLR_MODE ? ST_CLEAR : ST_IDLE;
      req_ready <= !CLR_MODE;
      busy      <= CLR_MODE;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            ram_addr  <= req_addr;
            ram_wdata <= req_wdata;
            ram_we    <= req_we;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          ram_we <= 1'b0;
          if (ram_we) begin
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            rsp_rdata <= ram_rdata;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        ST_CLEAR: begin
          if (!sweep_done) begin
            ram_addr  <= sweep_addr;
            ram_wdata <= CLR_VAL;
            ram_we    <= 1'b1;
          end else begin
            ram_we    <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          ram_we    <= 1'b0;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram16_access_ctrl.sv
// Self-checking bench for ram16_access_ctrl with a behavioural RAM16 beside the DUT.
module tb_ram16_access_ctrl;

`ifdef CLEAR_ON_RESET_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [3:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_rdata;
  logic        busy;
  logic [3:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_we;
  logic [15:0] ram_rdata;

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;

  logic [15:0] ram_mem [16];
  logic [15:0] ref_mem [16];
  bit          ref_known [16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign ram_rdata = ram_mem[ram_addr];
  always @(posedge clk) if (ram_we) ram_mem[ram_addr] <= ram_wdata;

  ram16_access_ctrl #(
    .ADDR_W  (4),
    .DATA_W  (16),
    .CLR_VAL (16'h0000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata)
  );

  typedef struct {
    bit          we;
    logic [3:0]  addr;
    logic [15:0] wdata;
    int unsigned hold;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", req_ready, 1);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [15:0] d, output int unsigned acc_cyc);
    wait_ready();
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    @(negedge clk);
    acc_cyc = cyc;
    req_valid = 1'b0; req_wdata = 16'($urandom);
    chk("wr_ram_we", ram_we, 1);
    chk("wr_ram_addr", ram_addr, a);
    chk("wr_ram_wdata", ram_wdata, d);
    chk("wr_ready_low", req_ready, 0);
    chk("wr_busy", busy, 1);
    @(negedge clk);
    chk("wr_we_drop", ram_we, 0);
    chk("wr_ready_back", req_ready, 1);
    chk("wr_addr_stable", ram_addr, a);
    ref_mem[a] = d;
    ref_known[a] = 1'b1;
  endtask

  task automatic do_read(input logic [3:0] a, input int unsigned hold, output logic [15:0] rdata);
    wait_ready();
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = 16'($urandom);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rd_ram_we", ram_we, 0);
    chk("rd_ram_addr", ram_addr, a);
    chk("rd_rsp_early", rsp_valid, 0);
    @(negedge clk);
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_ready_low", req_ready, 0);
    rdata = rsp_rdata;
    for (int unsigned h = 0; h < hold; h++) begin
      // A competing request while the response is pending must be ignored.
      req_valid = 1'b1; req_we = 1'b1; req_addr = 4'($urandom); req_wdata = 16'($urandom);
      @(negedge clk);
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp_rdata", rsp_rdata, rdata);
      chk("hold_ready_low", req_ready, 0);
      chk("hold_no_write", ram_we, 0);
      chk("hold_addr", ram_addr, a);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_done", rsp_valid, 0);
    chk("rsp_ready_back", req_ready, 1);
    chk("rsp_busy_clear", busy, 0);
  endtask

  initial begin
    int unsigned acc, prev_acc;
    bit          prev_wr;
    logic [15:0] rd, old9;

    tbl[0] = '{1'b1, 4'd5,  16'hBEEF, 0, 16'h0000};
    tbl[1] = '{1'b0, 4'd5,  16'h0000, 0, 16'hBEEF};
    tbl[2] = '{1'b1, 4'd3,  16'hA5C3, 0, 16'h0000};
    tbl[3] = '{1'b0, 4'd3,  16'h0000, 5, 16'hA5C3};
    tbl[4] = '{1'b1, 4'd15, 16'h1234, 0, 16'h0000};
    tbl[5] = '{1'b1, 4'd0,  16'h5678, 0, 16'h0000};
    tbl[6] = '{1'b0, 4'd15, 16'h0000, 1, 16'h1234};
    tbl[7] = '{1'b0, 4'd0,  16'h0000, 0, 16'h5678};

    for (int i = 0; i < 16; i++) ref_known[i] = 1'b0;

    #12;
    chk("rst_ram_we", ram_we, 0);
    chk("rst_req_ready", req_ready, !CLR);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_busy", busy, CLR);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    if (CLR) begin
      wait_ready();
      for (int i = 0; i < 16; i++) begin
        ref_mem[i] = 16'h0000;
        ref_known[i] = 1'b1;
      end
      for (int i = 0; i < 16; i++) begin
        do_read(4'(i), 0, rd);
        chk("clear_word", rd, 16'h0000);
      end
    end

    prev_wr = 1'b0;
    prev_acc = 0;
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].we) begin
        do_write(tbl[i].addr, tbl[i].wdata, acc);
        if (prev_wr) chk("b2b_spacing", acc - prev_acc, 2);
        prev_acc = acc;
        prev_wr = 1'b1;
      end else begin
        do_read(tbl[i].addr, tbl[i].hold, rd);
        chk("tbl_rdata", rd, tbl[i].exp);
        prev_wr = 1'b0;
      end
    end

    for (int i = 0; i < 16; i++) do_write(4'(i), 16'(i * 32'h1111), acc);
    for (int i = 15; i >= 0; i--) begin
      do_read(4'(i), 0, rd);
      chk("sweep_rdata", rd, 16'(i * 32'h1111));
    end

    for (int n = 0; n < 80; n++) begin
      logic [3:0]  a;
      logic [15:0] d;
      a = 4'($urandom);
      d = 16'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, d, acc);
      end else begin
        do_read(a, $urandom_range(0, 3), rd);
        if (ref_known[a]) chk("rand_rdata", rd, ref_mem[a]);
      end
    end

    old9 = ref_mem[9];
    wait_ready();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd9; req_wdata = 16'hDEAD;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_we_before", ram_we, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_we_now", ram_we, 0);
    chk("abort_req_ready", req_ready, !CLR);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_busy", busy, CLR);
    chk("abort_ram_addr", ram_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    if (CLR) begin
      for (int i = 0; i < 16; i++) ref_mem[i] = 16'h0000;
      old9 = 16'h0000;
    end
    @(negedge clk);
    do_read(4'd9, 0, rd);
    chk("abort_no_write", rd, old9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
